// File: rtl/alu32_seq_ctrl_if.sv
// Request/response bus between a client and the alu32 sequencer.
// A transfer happens on a rising edge where valid and ready are both high; valid holds its payload until then.
interface alu32_seq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [OPC_W-1:0]  req_opc;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic              rsp_ovf;
    logic              rsp_cout;
    logic              rsp_err;

    modport master (
        output req_valid, req_opc, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err
    );

    modport slave (
        input  req_valid, req_opc, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu32_seq_ctrl.sv
// Single-issue sequencer driving an external alu32: decodes opcodes into alu32 controls,
// runs SLT as a subtract pass followed by a LESS pass, and holds the result until consumed.
module alu32_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu32_seq_ctrl_if.slave   bus,
    output logic              busy,
    output logic [1:0]        state_o,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic              alu_a_invert,
    output logic              alu_b_invert,
    output logic              alu_cin,
    output logic [1:0]        alu_operation,
    output logic              alu_less,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_v,
    input  logic              alu_sign
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SLT2 = 2'd2, DONE = 2'd3} state_t;

    localparam logic [OPC_W-1:0] OPC_AND = OPC_W'(4'b0000);
    localparam logic [OPC_W-1:0] OPC_OR  = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OPC_SUB = OPC_W'(4'b0110);
    localparam logic [OPC_W-1:0] OPC_SLT = OPC_W'(4'b0111);
    localparam logic [OPC_W-1:0] OPC_NOR = OPC_W'(4'b1100);

    state_t            state_q;
    logic [OPC_W-1:0]  opc_q;
    logic [DATA_W-1:0] src1_q, src2_q, rsp_data_q;
    logic              a_inv_q, b_inv_q, cin_q, less_q;
    logic [1:0]        op_q;
    logic              req_ready_q, rsp_valid_q, busy_q;
    logic              rsp_zero_q, rsp_ovf_q, rsp_cout_q, rsp_err_q;

    // Control word {a_inv, b_inv, cin, op[1:0]} for the first (or only) alu32 pass.
    function automatic logic [4:0] decode(input logic [OPC_W-1:0] opc);
        logic [4:0] ctl;
        ctl = 5'b0_0_0_00;
        case (opc)
            OPC_AND: ctl = 5'b0_0_0_00;
            OPC_OR:  ctl = 5'b0_0_0_01;
            OPC_ADD: ctl = 5'b0_0_0_10;
            OPC_SUB: ctl = 5'b0_1_1_10;
            OPC_SLT: ctl = 5'b0_1_1_10;
            OPC_NOR: ctl = 5'b1_1_0_00;
            default: ctl = 5'b0_0_0_00;
        endcase
        return ctl;
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] opc);
        return (opc == OPC_AND) || (opc == OPC_OR) || (opc == OPC_ADD) ||
               (opc == OPC_SUB) || (opc == OPC_SLT) || (opc == OPC_NOR);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opc_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            {a_inv_q, b_inv_q, cin_q, op_q} <= 5'b0;
            less_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        opc_q       <= bus.req_opc;
                        src1_q      <= bus.req_a;
                        src2_q      <= bus.req_b;
                        {a_inv_q, b_inv_q, cin_q, op_q} <= decode(bus.req_opc);
                        less_q      <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (!is_legal(opc_q)) begin
                        rsp_data_q  <= '0;
                        rsp_zero_q  <= 1'b1;
                        rsp_ovf_q   <= 1'b0;
                        rsp_cout_q  <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        {a_inv_q, b_inv_q, cin_q, op_q} <= 5'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (opc_q == OPC_SLT) begin
                        // Corrected sign of A-B becomes the LESS input of bit 0.
                        {a_inv_q, b_inv_q, cin_q, op_q} <= 5'b0_1_1_11;
                        less_q      <= alu_sign;
                        state_q     <= SLT2;
                    end else begin
                        rsp_data_q  <= alu_result;
                        rsp_zero_q  <= (alu_result == '0);
                        rsp_ovf_q   <= (opc_q == OPC_ADD || opc_q == OPC_SUB) ? alu_v : 1'b0;
                        rsp_cout_q  <= (opc_q == OPC_ADD || opc_q == OPC_SUB) ? alu_cout : 1'b0;
                        rsp_err_q   <= 1'b0;
                        {a_inv_q, b_inv_q, cin_q, op_q} <= 5'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                SLT2: begin
                    rsp_data_q  <= alu_result;
                    rsp_zero_q  <= (alu_result == '0);
                    rsp_ovf_q   <= 1'b0;
                    rsp_cout_q  <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    {a_inv_q, b_inv_q, cin_q, op_q} <= 5'b0;
                    less_q      <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state_o       = state_q;
    assign busy          = busy_q;
    assign alu_src1      = src1_q;
    assign alu_src2      = src2_q;
    assign alu_a_invert  = a_inv_q;
    assign alu_b_invert  = b_inv_q;
    assign alu_cin       = cin_q;
    assign alu_operation = op_q;
    assign alu_less      = less_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Bench for alu32_seq_ctrl: behavioural alu32 attached to the control outputs, directed vectors,
// multi-cycle corner sequences and random ops checked against an arithmetic reference model.
module tb_alu32_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu32_seq_ctrl_if #(.DATA_W(32), .OPC_W(4)) bus ();

    logic        busy;
    logic [1:0]  state_o;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        alu_a_invert, alu_b_invert, alu_cin, alu_less;
    logic [1:0]  alu_operation;
    logic        alu_cout, alu_v, alu_sign;

    alu32_seq_ctrl #(.DATA_W(32), .OPC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .state_o(state_o),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_a_invert(alu_a_invert), .alu_b_invert(alu_b_invert), .alu_cin(alu_cin),
        .alu_operation(alu_operation), .alu_less(alu_less),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_v(alu_v), .alu_sign(alu_sign)
    );

    // Behavioural alu32: invert muxes, AND/OR/ripple-add, LESS feeds bit 0 only.
    logic [31:0] aa, bb;
    logic [32:0] sum;
    always_comb begin
        aa = alu_a_invert ? ~alu_src1 : alu_src1;
        bb = alu_b_invert ? ~alu_src2 : alu_src2;
        sum = {1'b0, aa} + {1'b0, bb} + {32'b0, alu_cin};
        alu_v = (aa[31] == bb[31]) && (sum[31] != aa[31]);
        alu_cout = sum[32];
        alu_sign = sum[31] ^ alu_v;
        case (alu_operation)
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            2'b10:   alu_result = sum[31:0];
            default: alu_result = {31'b0, alu_less};
        endcase
    end

    int checks = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {data, zero, ovf, cout, err} from plain integer arithmetic.
    function automatic logic [35:0] model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r, ua, ub;
        logic [31:0] d;
        logic ovf, cout, err;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ovf = 1'b0; cout = 1'b0; err = 1'b0; d = 32'b0;
        case (opc)
            4'b0000: d = a & b;
            4'b0001: d = a | b;
            4'b0010: begin
                d = a + b; r = sa + sb;
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                cout = (ua + ub) > 64'h0000_0000_ffff_ffff;
            end
            4'b0110: begin
                d = a - b; r = sa - sb;
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                cout = (a >= b);
            end
            4'b0111: d = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: d = ~(a | b);
            default: err = 1'b1;
        endcase
        return {d, (d == 32'b0), ovf, cout, err};
    endfunction

    // Issue one request at a negedge, wait for the response, check it and consume it.
    // During 'hold' cycles rsp_ready stays low; with 'bp' set a second request is offered meanwhile.
    task automatic run_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic bp);
        int n;
        logic [35:0] e;
        logic [35:0] got;
        chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_opc = opc; bus.req_a = a; bus.req_b = b;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
        n = 1;
        while (!bus.rsp_valid && n < 12) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        if (!bus.rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, required within 3", n);
            return;
        end
        chk("latency", n, (opc == 4'b0111) ? 32'd3 : 32'd2);
        got = {bus.rsp_data, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_err};
        chk("rsp_data", got[35:4], e[35:4]);
        chk("rsp_flags_zocE", {28'b0, got[3:0]}, {28'b0, e[3:0]});
        chk("done_ctrl_zero", {26'b0, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less}, 32'd0);
        chk("done_src1_held", alu_src1, a);
        for (int i = 0; i < hold; i++) begin
            if (bp) begin
                bus.req_valid = 1'b1; bus.req_opc = 4'b0110; bus.req_a = 32'h1234; bus.req_b = 32'h1;
            end
            @(posedge clk); @(negedge clk);
            got = {bus.rsp_data, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_err};
            chk("hold_rsp_stable", got[35:4], e[35:4]);
            chk("hold_flags_stable", {28'b0, got[3:0]}, {28'b0, e[3:0]});
            chk("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            if (bp) chk("hold_req_ready_low", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        chk("consume_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("consume_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("consume_not_busy", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] a, b, data;
        logic        zero, ovf, cout, err;
    } vec_t;
    vec_t vecs[13];

    logic [3:0]  legal_opc[6];
    logic [31:0] corner[5];

    initial begin
        bus.req_valid = 1'b0; bus.req_opc = 4'b0; bus.req_a = 32'b0; bus.req_b = 32'b0;
        bus.rsp_ready = 1'b0;

        vecs[0]  = '{4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0000, 32'hf0f0f0f0, 32'h0ff00ff0, 32'h00f000f0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0001, 32'hf0f0f0f0, 32'h0ff00ff0, 32'hfff0fff0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1100, 32'hf0f0f0f0, 32'h0ff00ff0, 32'h000f000f, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0111, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0111, 32'h80000000, 32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0111, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1111, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'b0010, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{4'b0010, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'b0011, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};

        legal_opc[0] = 4'b0000; legal_opc[1] = 4'b0001; legal_opc[2] = 4'b0010;
        legal_opc[3] = 4'b0110; legal_opc[4] = 4'b0111; legal_opc[5] = 4'b1100;
        corner[0] = 32'h0; corner[1] = 32'h7fffffff; corner[2] = 32'h80000000;
        corner[3] = 32'hffffffff; corner[4] = 32'h1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp", {bus.rsp_data[27:0], bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_err} | {bus.rsp_data[31:28], 28'b0}, 32'd0);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset_alu_ctrl", {26'b0, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less}, 32'd0);
        chk("reset_alu_src", alu_src1 | alu_src2, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            exp_q.push_back({vecs[i].data, vecs[i].zero, vecs[i].ovf, vecs[i].cout, vecs[i].err});
            run_op(vecs[i].opc, vecs[i].a, vecs[i].b, 0, 1'b0);
        end

        // Back-pressure: response held for 5 cycles while a new request is offered.
        exp_q.push_back(model(4'b0010, 32'h0000_1000, 32'h0000_0234));
        run_op(4'b0010, 32'h0000_1000, 32'h0000_0234, 5, 1'b1);
        exp_q.push_back(model(4'b0111, 32'hfffffff0, 32'h00000003));
        run_op(4'b0111, 32'hfffffff0, 32'h00000003, 5, 1'b1);

        // Reset while the SLT second pass is in flight.
        bus.req_valid = 1'b1; bus.req_opc = 4'b0111; bus.req_a = 32'h5; bus.req_b = 32'h9;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("slt2_busy", {31'b0, busy}, 32'd1);
        chk("slt2_ctrl", {26'b0, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less}, 32'b0_1_1_11_1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_alu_ctrl", {26'b0, alu_a_invert, alu_b_invert, alu_cin, alu_operation, alu_less}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk("post_rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        end

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  opc;
            logic [31:0] a, b;
            opc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : legal_opc[$urandom_range(0, 5)];
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            exp_q.push_back(model(opc, a, b));
            run_op(opc, a, b, $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1);
    end
endmodule
